// File: rtl/rave_fu_pkg.sv
// Shared definitions for the RAVE arithmetic functional units: op encodings
// and the default-width result record carried toward the CDB.
package rave_fu_pkg;

   localparam int FU_XLEN  = 32;
   localparam int FU_TAG_W = 8;

   typedef enum logic [2:0] {
      ARITH_ADDSUB = 3'b000,
      ARITH_SLT    = 3'b010,
      ARITH_SLTU   = 3'b011,
      ARITH_MIN    = 3'b100,
      ARITH_MAX    = 3'b101
   } arith_type_e;

   typedef struct packed {
      logic                valid;
      logic [FU_XLEN-1:0]  result;
      logic [FU_TAG_W-1:0] tag;
      logic                overflow;
      logic                illegal;
   } fu_result_t;

endpackage

// File: rtl/arith_fu_stage.sv
// One slot of the arithmetic FU pipeline: holds a valid bit and an opaque payload,
// loads from upstream whenever it is empty or its contents move downstream.
module arith_fu_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         down_take,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         take,
   output logic         valid,
   output logic [W-1:0] data
);

   // Empty slots keep absorbing, so bubbles collapse under a stall
   assign take = !valid || down_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (take) begin
         valid <= up_valid;
         if (up_valid)
            data <= up_data;
      end
   end

endmodule

// File: rtl/arithmetic_fu_pipe.sv
// Pipelined arithmetic functional unit: add/sub/slt/sltu/min/max with a signed
// overflow flag, PIPE_DEPTH stages of valid/ready pipeline, global flush.
module arithmetic_fu_pipe
   import rave_fu_pkg::*;
#(
   parameter  int XLEN       = 32,
   parameter  int ROB_SIZE   = 256,
   parameter  int PIPE_DEPTH = 2,
   localparam int TAG_W      = $clog2(ROB_SIZE),
   localparam int OCC_W      = $clog2(PIPE_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             additional_info,
   input  logic [2:0]       arithmetic_type,
   input  logic [TAG_W-1:0] rob_entry_in,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] rob_entry,
   output logic             overflow,
   output logic             illegal,
   output logic [OCC_W-1:0] occupancy
);

   typedef struct packed {
      logic [XLEN-1:0]  result;
      logic [TAG_W-1:0] tag;
      logic             overflow;
      logic             illegal;
   } stage_t;

   localparam int PW = $bits(stage_t);

   logic [XLEN-1:0] b_op;
   logic [XLEN-1:0] sum;
   logic            lt_s;
   logic            lt_u;
   logic            lt_mm;
   stage_t          alu_pkt;
   stage_t          last_pkt;
   logic            accept;
   logic            retire;

   always_comb begin
      // Subtraction as rs1 + ~rs2 + 1 so one adder serves both
      b_op  = additional_info ? ~rs2 : rs2;
      sum   = rs1 + b_op + XLEN'(additional_info);
      lt_s  = $signed(rs1) < $signed(rs2);
      lt_u  = rs1 < rs2;
      lt_mm = additional_info ? lt_u : lt_s;

      alu_pkt          = '0;
      alu_pkt.tag      = rob_entry_in;
      case (arith_type_e'(arithmetic_type))
         ARITH_ADDSUB: begin
            alu_pkt.result   = sum;
            alu_pkt.overflow = (rs1[XLEN-1] == b_op[XLEN-1]) &&
                               (sum[XLEN-1] != rs1[XLEN-1]);
         end
         ARITH_SLT:  alu_pkt.result = XLEN'(lt_s);
         ARITH_SLTU: alu_pkt.result = XLEN'(lt_u);
         ARITH_MIN:  alu_pkt.result = lt_mm ? rs1 : rs2;
         ARITH_MAX:  alu_pkt.result = lt_mm ? rs2 : rs1;
         default:    alu_pkt.illegal = 1'b1;
      endcase
   end

   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_st
      logic          up_valid;
      logic [PW-1:0] up_data;
      logic          down_take;
      logic          take_l;
      logic          valid_l;
      logic [PW-1:0] data_l;

      if (i == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_data  = alu_pkt;
      end else begin : g_body
         assign up_valid = g_st[i-1].valid_l;
         assign up_data  = g_st[i-1].data_l;
      end

      if (i == PIPE_DEPTH - 1) begin : g_tail
         assign down_take = out_ready;
      end else begin : g_mid
         assign down_take = g_st[i+1].take_l;
      end

      arith_fu_stage #(.W(PW)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .down_take (down_take),
         .up_valid  (up_valid),
         .up_data   (up_data),
         .take      (take_l),
         .valid     (valid_l),
         .data      (data_l)
      );
   end

   assign in_ready  = g_st[0].take_l && !flush;
   assign last_pkt  = stage_t'(g_st[PIPE_DEPTH-1].data_l);
   assign out_valid = g_st[PIPE_DEPTH-1].valid_l;
   assign result    = last_pkt.result;
   assign rob_entry = last_pkt.tag;
   assign overflow  = last_pkt.overflow;
   assign illegal   = last_pkt.illegal;

   assign accept = in_valid && in_ready;
   assign retire = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else if (accept && !retire)
         occupancy <= occupancy + OCC_W'(1);
      else if (retire && !accept)
         occupancy <= occupancy - OCC_W'(1);
   end

endmodule

// File: tb/tb_arithmetic_fu_pipe.sv
// Scoreboard bench for arithmetic_fu_pipe: expected results are queued on accept
// and a negedge monitor compares every retiring output against them.
`timescale 1ns/1ps
module tb_arithmetic_fu_pipe;
   import rave_fu_pkg::*;

   localparam int XLEN     = 32;
   localparam int ROB_SIZE = 256;
   localparam int PD       = 2;
   localparam int TAG_W    = 8;
   localparam int OCC_W    = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             additional_info = 1'b0;
   logic [2:0]       arithmetic_type = '0;
   logic [TAG_W-1:0] rob_entry_in = '0;
   logic [XLEN-1:0]  rs1 = '0;
   logic [XLEN-1:0]  rs2 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] rob_entry;
   logic             overflow;
   logic             illegal;
   logic [OCC_W-1:0] occupancy;

   arithmetic_fu_pipe #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .PIPE_DEPTH(PD)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .additional_info(additional_info), .arithmetic_type(arithmetic_type),
      .rob_entry_in(rob_entry_in), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .rob_entry(rob_entry),
      .overflow(overflow), .illegal(illegal), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   fu_result_t exp_q[$];
   int errors = 0;
   int checks = 0;
   int n_popped = 0;
   bit rand_bp = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference behaviour from plain signed/unsigned arithmetic
   function automatic fu_result_t model(input logic [2:0] op, input logic info,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] tag);
      fu_result_t r;
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0;
      r.valid = 1'b1;
      r.tag = tag;
      case (op)
         3'd0: begin
            s = info ? sa - sb : sa + sb;
            r.result = s[31:0];
            r.overflow = (s != longint'($signed(s[31:0])));
         end
         3'd2: r.result = (sa < sb) ? 32'd1 : 32'd0;
         3'd3: r.result = (a < b) ? 32'd1 : 32'd0;
         3'd4: r.result = info ? ((a < b) ? a : b) : ((sa < sb) ? a : b);
         3'd5: r.result = info ? ((a < b) ? b : a) : ((sa < sb) ? b : a);
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

   // Monitor: compare every handshake, and check outputs hold while stalled
   fu_result_t held;
   bit stalled = 0;
   always @(negedge clk) begin
      fu_result_t e;
      #1;
      if (rst_n && stalled && out_valid) begin
         check("hold_result", 64'(result), 64'(held.result));
         check("hold_tag", 64'(rob_entry), 64'(held.tag));
      end
      stalled = 0;
      if (rst_n && out_valid) begin
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got tag 0x%0h result 0x%0h, required no output",
                        rob_entry, result);
            end else begin
               e = exp_q.pop_front();
               check("result", 64'(result), 64'(e.result));
               check("tag", 64'(rob_entry), 64'(e.tag));
               check("overflow", 64'(overflow), 64'(e.overflow));
               check("illegal", 64'(illegal), 64'(e.illegal));
               n_popped++;
            end
         end else begin
            stalled = 1;
            held.result = result;
            held.tag = rob_entry;
         end
      end
   end

   task automatic present(input logic [2:0] op, input logic info,
                          input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
      in_valid = 1'b1;
      arithmetic_type = op;
      additional_info = info;
      rs1 = a;
      rs2 = b;
      rob_entry_in = tag;
   endtask

   task automatic issue(input logic [2:0] op, input logic info,
                        input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
      bit done = 0;
      for (int k = 0; k < 500 && !done; k++) begin
         @(negedge clk);
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         present(op, info, a, b, tag);
         #1;
         if (in_ready) begin
            exp_q.push_back(model(op, info, a, b, tag));
            done = 1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got no accept for tag 0x%0h, required accept", tag);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(negedge clk);
         in_valid = 1'b0;
         out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         k++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h7FFFFFFF;
         2: return 32'h80000000;
         3: return 32'hFFFFFFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int acc;
      int n0;
      logic [31:0] ops_a[4];

      // Reset values
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_rob_entry", 64'(rob_entry), 64'd0);
      check("rst_flags", 64'({overflow, illegal}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Latency: sub 5-7, tag 0x3A
      @(negedge clk);
      present(3'b000, 1'b1, 32'd5, 32'd7, 8'h3A);
      #1;
      check("lat_in_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(model(3'b000, 1'b1, 32'd5, 32'd7, 8'h3A));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("lat_early_valid", 64'(out_valid), 64'd0);
      check("lat_occ1", 64'(occupancy), 64'd1);
      @(negedge clk);
      #1;
      check("lat_valid", 64'(out_valid), 64'd1);
      check("lat_sub_result", 64'(result), 64'hFFFFFFFE);
      check("lat_sub_tag", 64'(rob_entry), 64'h3A);

      // Directed corner ops
      issue(3'b000, 1'b0, 32'h7FFFFFFF, 32'h1, 8'h01);
      issue(3'b000, 1'b1, 32'h80000000, 32'h1, 8'h02);
      issue(3'b010, 1'b0, 32'hFFFFFFFF, 32'h1, 8'h03);
      issue(3'b011, 1'b0, 32'hFFFFFFFF, 32'h1, 8'h04);
      issue(3'b100, 1'b0, 32'hFFFFFFFF, 32'h1, 8'h05);
      issue(3'b100, 1'b1, 32'hFFFFFFFF, 32'h1, 8'h06);
      issue(3'b101, 1'b0, 32'hFFFFFFFF, 32'h1, 8'h07);
      issue(3'b101, 1'b1, 32'hFFFFFFFF, 32'h1, 8'h08);
      issue(3'b110, 1'b0, 32'h1234, 32'h5678, 8'h11);
      issue(3'b001, 1'b1, 32'h1, 32'h1, 8'h12);
      issue(3'b111, 1'b0, 32'h1, 32'h1, 8'h13);
      drain();

      // Backpressure: stream 4 ops with out_ready low
      ops_a[0] = 32'd10; ops_a[1] = 32'd20; ops_a[2] = 32'd30; ops_a[3] = 32'd40;
      @(negedge clk);
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         present(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc));
         #1;
         if (in_ready) begin
            exp_q.push_back(model(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc)));
            acc++;
         end
      end
      check("bp_accepts", 64'(acc), 64'(PD));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_occupancy", 64'(occupancy), 64'(PD));
      @(negedge clk);
      out_ready = 1'b1;
      n0 = n_popped;
      present(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc));
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(model(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc)));
      acc++;
      @(negedge clk);
      present(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc));
      #1;
      check("bp_stream_in_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(model(3'b000, 1'b0, ops_a[acc], 32'd1, 8'(8'h40 + acc)));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      check("bp_throughput", 64'(n_popped - n0), 64'd4);
      drain();

      // Flush with an op presented on the flush cycle
      @(negedge clk);
      out_ready = 1'b0;
      issue(3'b000, 1'b0, 32'd100, 32'd1, 8'h21);
      issue(3'b000, 1'b0, 32'd200, 32'd1, 8'h22);
      @(negedge clk);
      present(3'b000, 1'b0, 32'd300, 32'd1, 8'h23);
      flush = 1'b1;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_occupancy", 64'(occupancy), 64'd0);
      out_ready = 1'b1;
      idle(4);
      issue(3'b011, 1'b0, 32'd1, 32'd2, 8'h24);
      drain();

      // Randomised traffic with random backpressure
      rand_bp = 1;
      for (int n = 0; n < 300; n++) begin
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rand_val(), rand_val(),
               8'($urandom_range(0, 255)));
         if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
      end
      rand_bp = 0;
      drain();

      // Asynchronous reset mid-stream
      @(negedge clk);
      out_ready = 1'b0;
      issue(3'b000, 1'b0, 32'd7, 32'd8, 8'h31);
      issue(3'b000, 1'b0, 32'd9, 32'd8, 8'h32);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre_rst_out_valid", 64'(out_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_occupancy", 64'(occupancy), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(3);
      issue(3'b101, 1'b1, 32'd3, 32'd4, 8'h33);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
